// File: rtl/led_frame_receiver.sv
// Serial LED pixel-word receiver: sof-framed bit stream into a 2-entry output FIFO.
// Optional frame tagging compiled in with the RX_FRAME_IDX_EN macro.
module led_frame_receiver #(
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned FRAME_N = 17
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              bit_en_in,
  input  logic              bit_in,
  input  logic              sof_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid_out,
  input  logic              word_ready_in,
  output logic              overflow_out,
  output logic              sync_err_out,
  output logic [4:0]        frame_idx_out
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;
  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  logic              state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] tail_q;
  logic [1:0]        count_q;
  logic [WORD_W-1:0] new_word;
  logic              push;
  logic              pop;

  always_comb begin
    new_word = {shift_q[WORD_W-2:0], bit_in};
    push     = bit_en_in && (state == ST_SHIFT) && !sof_in &&
               (bit_cnt == CNT_W'(WORD_W - 1));
    pop      = word_valid_out && word_ready_in;
  end

  // Left shift puts pixel 0 in the MSB once all WORD_W bits have arrived.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift_q      <= '0;
      sync_err_out <= 1'b0;
    end else begin
      sync_err_out <= 1'b0;
      if (bit_en_in) begin
        if (sof_in) begin
          sync_err_out <= (state == ST_SHIFT);
          state        <= ST_SHIFT;
          bit_cnt      <= CNT_W'(1);
          shift_q      <= WORD_W'(bit_in);
        end else if (state == ST_SHIFT) begin
          shift_q <= new_word;
          if (push) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      word_out       <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      word_valid_out <= 1'b0;
      overflow_out   <= 1'b0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push) begin
            word_out       <= new_word;
            count_q        <= 2'd1;
            word_valid_out <= 1'b1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            word_out <= new_word;
          end else if (push) begin
            tail_q  <= new_word;
            count_q <= 2'd2;
          end else if (pop) begin
            count_q        <= 2'd0;
            word_valid_out <= 1'b0;
          end
        end
        2'd2: begin
          if (pop) begin
            word_out <= tail_q;
            if (push) tail_q <= new_word;
            else      count_q <= 2'd1;
          end else if (push) begin
            overflow_out <= 1'b1;
          end
        end
        default: begin
          count_q        <= '0;
          word_valid_out <= 1'b0;
        end
      endcase
    end
  end

`ifdef RX_FRAME_IDX_EN
  logic [4:0] tag_cnt;
  logic [4:0] tail_tag;

  // Tag slots follow the word slots; the counter advances even on dropped words.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tag_cnt       <= '0;
      tail_tag      <= '0;
      frame_idx_out <= '0;
    end else begin
      if (push)
        tag_cnt <= (tag_cnt == 5'(FRAME_N - 1)) ? 5'd0 : tag_cnt + 5'd1;
      case (count_q)
        2'd0: if (push) frame_idx_out <= tag_cnt;
        2'd1: begin
          if (push && pop) frame_idx_out <= tag_cnt;
          else if (push)   tail_tag      <= tag_cnt;
        end
        2'd2: begin
          if (pop) begin
            frame_idx_out <= tail_tag;
            if (push) tail_tag <= tag_cnt;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign frame_idx_out = '0;
`endif

endmodule
